riscv_lsu: RTL and testbench
============================

// Module: riscv_lsu
// PURPOSE
// - Load/store unit downstream of decoder_riscv. Consumes mem_req/mem_we/mem_size, plus the ALU address and rs2 data.
// - Runs a multi-cycle handshake with data memory and stalls the core until the access completes.
// - Generates byte enables and store lane replication; sign/zero-extends load data for writeback (WB_LSU_DATA).
// PARAMETERS
// - ADDR_W   32   width of core_addr_i / mem_addr_o
// PORTS
// - clk_i          in   1       sole clock, rising edge
// - rst_i          in   1       asynchronous, active-high reset
// - core_req_i     in   1       access request (decoder mem_req_o)
// - core_we_i      in   1       1=store, 0=load (decoder mem_we_o)
// - core_size_i    in   3       LDST_B=0, H=1, W=2, BU=4, HU=5
// - core_addr_i    in   ADDR_W  byte address (ALU result)
// - core_wd_i      in   32      store data (rs2)
// - core_rd_o      out  32      extended load data
// - core_stall_o   out  1       1 = hold PC/pipeline
// - misalign_o     out  1       misaligned-access pulse (MISALIGN_CHECK_EN only, else tied 0)
// - mem_req_o      out  1       memory request
// - mem_we_o       out  1       memory write enable
// - mem_be_o       out  4       byte enables
// - mem_addr_o     out  ADDR_W  memory byte address
// - mem_wd_o       out  32      memory write data
// - mem_rd_i       in   32      memory read word
// - mem_ready_i    in   1       memory completed current request
// BEHAVIOUR
// - Reset: state=IDLE; all outputs and internal registers 0. Reset mid-access drops mem_req_o immediately and discards the access.
// - FSM IDLE -> REQ -> DONE -> IDLE.
//   - IDLE & core_req_i: latch we/size/addr/be/wd, go REQ.
//   - REQ: mem_req_o=1 with latched fields held stable. On mem_ready_i: if load, register extended data into core_rd_o; go DONE.
//   - DONE: one cycle, then IDLE. core_req_i in the IDLE that follows starts a new access.
// - core_stall_o = core_req_i & (state != DONE). This is combinational, so stall asserts in the request cycle.
// - Core holds its inputs stable while stalled. Input changes during REQ are ignored (latched copy used).
// - Min latency: req cycle 0, ready in cycle 1, stall low in cycle 2. ready in cycle N gives DONE in cycle N+1.
// - mem_ready_i is ignored outside REQ. mem_rd_i is sampled only on the REQ&ready edge.
// - mem_be_o by size (o = addr[1:0]):
//   - B/BU: 4'b0001<<o
//   - H/HU: 4'b0011<<{addr[1],1'b0}
//   - W: 4'b1111
//   - size 3/6/7: 4'b0000, access still completes, load result 0.
// - mem_wd_o: B={4{wd[7:0]}}, H={2{wd[15:0]}}, W=wd.
// - mem_addr_o = latched full byte address (no word alignment).
// - Load extension from the lane selected by addr:
//   - B: sign-extend byte o
//   - BU: zero-extend byte o
//   - H: sign-extend half addr[1]
//   - HU: zero-extend half addr[1]
//   - W: word
// - Stores leave core_rd_o unchanged; mem_we_o=1 throughout REQ.
// CONFIGURATION
// - MISALIGN_CHECK_EN defined:
//   - H/HU with addr[0]=1, or W with addr[1:0]!=0, goes IDLE->DONE directly with no mem_req_o.
//   - misalign_o=1 for that DONE cycle only; core_rd_o unchanged.
// - MISALIGN_CHECK_EN undefined: misalign_o tied 0; low address bits outside the lane rules above are ignored.
// TESTING
// - LW addr 0x100, mem_rd=0xDEADBEEF, ready 1 cycle after req:
//   - be=1111, stall high 2 cycles, core_rd=0xDEADBEEF in DONE.
// - LB addr 0x103, mem_rd=0x80FFFFFF:
//   - be=1000, core_rd=0xFFFFFF80.
//   - LBU same access: core_rd=0x00000080.
// - SH addr 0x102, wd=0x1234ABCD:
//   - be=1100, mem_wd=0xABCDABCD, mem_we=1, core_rd unchanged.
// - LH, ready withheld 5 cycles:
//   - mem_req/addr/be stable all 5 cycles, stall stays high, DONE exactly one cycle after ready.
// - rst_i asserted while in REQ:
//   - mem_req_o and core_rd_o go 0 asynchronously, FSM IDLE, next request starts clean.
// - MISALIGN_CHECK_EN, LW addr 0x101:
//   - no mem_req_o, misalign_o=1 one cycle, stall low that cycle.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: multi-cycle data-memory handshake with byte enables, store lane replication and load extension.
// Optional MISALIGN_CHECK_EN: misaligned H/W accesses complete without a memory request and pulse misalign_o.
module riscv_lsu #(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [2:0]        core_size_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [31:0]       core_wd_i,
   output logic [31:0]       core_rd_o,
   output logic              core_stall_o,
   output logic              misalign_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wd_o,
   input  logic [31:0]       mem_rd_i,
   input  logic              mem_ready_i
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t            state_reg, state_next;
   logic              we_reg;
   logic [2:0]        size_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [3:0]        be_reg, be_next;
   logic [31:0]       wd_reg, wd_next;
   logic [31:0]       rd_reg;
   logic              misalign_reg;
   logic              misaligned;
   logic [1:0]        offset;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       load_data;

   assign offset = core_addr_i[1:0];

   always_comb begin
      be_next = 4'b0000;
      wd_next = core_wd_i;
      case (core_size_i)
         3'd0, 3'd4: begin
            be_next = 4'b0001 << offset;
            wd_next = {4{core_wd_i[7:0]}};
         end
         3'd1, 3'd5: begin
            be_next = 4'b0011 << {offset[1], 1'b0};
            wd_next = {2{core_wd_i[15:0]}};
         end
         3'd2: begin
            be_next = 4'b1111;
            wd_next = core_wd_i;
         end
         default: begin
            be_next = 4'b0000;
            wd_next = core_wd_i;
         end
      endcase
   end

`ifdef MISALIGN_CHECK_EN
   assign misaligned = (((core_size_i == 3'd1) || (core_size_i == 3'd5)) && offset[0])
                     || ((core_size_i == 3'd2) && (offset != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   // Lane selection uses the latched address; the memory returns the whole word.
   assign byte_sel = mem_rd_i[{addr_reg[1:0], 3'b000} +: 8];
   assign half_sel = mem_rd_i[{addr_reg[1], 4'b0000} +: 16];

   always_comb begin
      load_data = 32'h0;
      case (size_reg)
         3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
         3'd4:    load_data = {24'h0, byte_sel};
         3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
         3'd5:    load_data = {16'h0, half_sel};
         3'd2:    load_data = mem_rd_i;
         default: load_data = 32'h0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (core_req_i) state_next = misaligned ? DONE : REQ;
         REQ:     if (mem_ready_i) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg    <= IDLE;
         we_reg       <= 1'b0;
         size_reg     <= 3'd0;
         addr_reg     <= '0;
         be_reg       <= 4'b0000;
         wd_reg       <= 32'h0;
         rd_reg       <= 32'h0;
         misalign_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         misalign_reg <= (state_reg == IDLE) && core_req_i && misaligned;
         if ((state_reg == IDLE) && core_req_i) begin
            we_reg   <= core_we_i;
            size_reg <= core_size_i;
            addr_reg <= core_addr_i;
            be_reg   <= be_next;
            wd_reg   <= wd_next;
         end
         if ((state_reg == REQ) && mem_ready_i && !we_reg) begin
            rd_reg <= load_data;
         end
      end
   end

   assign core_stall_o = core_req_i && (state_reg != DONE);
   assign core_rd_o    = rd_reg;
   assign misalign_o   = misalign_reg;
   assign mem_req_o    = (state_reg == REQ);
   assign mem_we_o     = (state_reg == REQ) && we_reg;
   assign mem_be_o     = be_reg;
   assign mem_addr_o   = addr_reg;
   assign mem_wd_o     = wd_reg;

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: stimulus pushes expected results, a monitor checks memory-side cycles and completions.
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_we;
   logic [2:0]  core_size;
   logic [31:0] core_addr, core_wd;
   logic [31:0] core_rd;
   logic        core_stall, misalign;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wd, mem_rd;
   logic        mem_ready;

   always #5 clk = ~clk;

   riscv_lsu #(.ADDR_W(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
      .core_addr_i(core_addr), .core_wd_i(core_wd),
      .core_rd_o(core_rd), .core_stall_o(core_stall), .misalign_o(misalign),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
      .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
      .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        chk_wd;
      logic [3:0]  be;
      logic [31:0] rd;
      logic        mis;
      int          req_cycles;
   } exp_t;

   exp_t        q[$];
   int          compared = 0;
   int          mismatched = 0;
   int          req_cnt = 0;
   int          stall_cnt = 0;
   logic        mon_en = 1'b1;
   logic [31:0] rd_model = 32'h0;
   int          resp_delay = 0;
   logic [31:0] resp_data = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %h required %h @%0t", name, act, req, $time);
      end
   endtask

   // Reference: byte-lane view of the access, independent of how the RTL encodes it.
   function automatic exp_t model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rdata,
                                  input logic [31:0] prev, input int delay);
      exp_t        e;
      int          nb, lane;
      logic [31:0] v;
      nb = 0; lane = 0;
      case (size)
         3'd0, 3'd4: begin nb = 1; lane = int'(addr[1:0]); end
         3'd1, 3'd5: begin nb = 2; lane = addr[1] ? 2 : 0; end
         3'd2:       begin nb = 4; lane = 0; end
         default:    begin nb = 0; lane = 0; end
      endcase
      e.we = we; e.addr = addr; e.mis = 1'b0; e.req_cycles = delay + 1;
      e.be = 4'b0000;
      for (int i = 0; i < nb; i++) e.be[lane + i] = 1'b1;
      e.chk_wd = (nb > 0);
      e.wd = 32'h0;
      if (nb > 0) for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = wd[8*(i % nb) +: 8];
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = rdata[8*(lane + i) +: 8];
      if (size < 3'd2 && nb > 0 && v[8*nb - 1])
         for (int j = 8*nb; j < 32; j++) v[j] = 1'b1;
      e.rd = we ? prev : v;
`ifdef MISALIGN_CHECK_EN
      if ((nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00)) begin
         e.mis = 1'b1; e.rd = prev; e.req_cycles = 0;
      end
`endif
      return e;
   endfunction

   task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input int delay);
      exp_t e;
      int   n;
      e = model(we, size, addr, wd, rdata, rd_model, delay);
      rd_model = e.rd;
      q.push_back(e);
      resp_delay = delay;
      resp_data  = rdata;
      @(negedge clk);
      core_we = we; core_size = size; core_addr = addr; core_wd = wd; core_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (core_stall && n < 200);
      if (core_stall) begin
         mismatched++;
         $display("FAIL timeout: stall still %b after %0d cycles, required 0", core_stall, n);
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
         $fatal(1, "access timeout");
      end
      @(posedge clk); #1;
      core_req = 1'b0;
      core_we = 1'($urandom); core_size = 3'($urandom); core_addr = $urandom; core_wd = $urandom;
   endtask

   // Memory responder: ready after resp_delay REQ cycles; noise on ready outside REQ.
   initial begin
      int cnt;
      cnt = 0; mem_ready = 1'b0; mem_rd = 32'h0;
      forever begin
         @(negedge clk); #1;
         if (mem_req) begin
            if (cnt == 0) begin
               mem_ready = 1'b1; mem_rd = resp_data;
            end else begin
               mem_ready = 1'b0; mem_rd = $urandom; cnt--;
            end
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rd = $urandom;
            cnt = resp_delay;
         end
      end
   end

   // Monitor: checks every REQ cycle against the head entry and pops it at completion.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #2;
         if (!mon_en || rst) continue;
         if (mem_req) begin
            if (q.size() == 0) begin
               check("unexpected_mem_req", mem_req, 1'b0);
            end else begin
               req_cnt++;
               check("mem_addr", mem_addr, q[0].addr);
               check("mem_be", 32'(mem_be), 32'(q[0].be));
               check("mem_we", 32'(mem_we), 32'(q[0].we));
               if (q[0].chk_wd) check("mem_wd", mem_wd, q[0].wd);
            end
         end
         if (core_req && core_stall) stall_cnt++;
         if (core_req && !core_stall) begin
            if (q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("core_rd", core_rd, e.rd);
               check("misalign_done", 32'(misalign), 32'(e.mis));
               check("req_cycles", req_cnt, e.req_cycles);
               check("stall_cycles", stall_cnt, e.req_cycles + 1);
            end
            req_cnt = 0;
            stall_cnt = 0;
         end else begin
            check("misalign_idle", 32'(misalign), 32'd0);
         end
      end
   end

   initial begin
      logic [2:0] valid_sizes [5];
      logic [2:0] bad_sizes [3];
      int         r;
      logic [2:0] sz;
      valid_sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      bad_sizes   = '{3'd3, 3'd6, 3'd7};
      rst = 1'b1;
      core_req = 1'b0; core_we = 1'b0; core_size = 3'd0; core_addr = 32'h0; core_wd = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_mem_req", 32'(mem_req), 32'd0);
      check("reset_mem_we", 32'(mem_we), 32'd0);
      check("reset_mem_be", 32'(mem_be), 32'd0);
      check("reset_mem_addr", mem_addr, 32'h0);
      check("reset_mem_wd", mem_wd, 32'h0);
      check("reset_core_rd", core_rd, 32'h0);
      check("reset_stall", 32'(core_stall), 32'd0);
      check("reset_misalign", 32'(misalign), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
      access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FFFFFF, 1);
      access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FFFFFF, 1);
      access(1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 0);
      access(1'b0, 3'd1, 32'h202, 32'h0, 32'h80017FFE, 5);
`ifdef MISALIGN_CHECK_EN
      access(1'b0, 3'd2, 32'h101, 32'h0, 32'h11111111, 0);
`endif

      // Reset in the middle of a long REQ phase.
      mon_en = 1'b0;
      resp_delay = 30;
      @(negedge clk);
      core_we = 1'b0; core_size = 3'd2; core_addr = 32'h300; core_req = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("pre_reset_mem_req", 32'(mem_req), 32'd1);
      rst = 1'b1;
      #1;
      check("midreset_mem_req", 32'(mem_req), 32'd0);
      check("midreset_core_rd", core_rd, 32'h0);
      check("midreset_mem_addr", mem_addr, 32'h0);
      core_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      rd_model = 32'h0;
      req_cnt = 0;
      stall_cnt = 0;
      mon_en = 1'b1;
      access(1'b0, 3'd5, 32'h402, 32'h0, 32'hC0DE1234, 2);

      for (int k = 0; k < 250; k++) begin
         r = $urandom_range(0, 19);
         sz = (r < 17) ? valid_sizes[r % 5] : bad_sizes[r - 17];
         access(($urandom_range(0, 2) == 0), sz, $urandom, $urandom, $urandom, $urandom_range(0, 6));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      check("queue_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
